// File: rtl/fft_pkg.sv
// Shared constants, sample type and bit-reversal helper for the FFT output reorder path.
package fft_pkg;

  localparam int DW   = 16;
  localparam int LOGN = 6;
  localparam int N    = 2 ** LOGN;
  localparam int HALF = N / 2;
  localparam int AW   = LOGN - 1;

  // One complex sample as stored in a bank entry.
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } sample_t;

  // Reverse the low 'width' bits of v; bits above 'width' come back as zero.
  function automatic int bitrev(input int v, input int width);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < width && v[i]) begin
        r[width-1-i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Pair-input / serial-output bus of the FFT output reorder block.
interface fft_out_reorder_if;
  import fft_pkg::*;

  logic                 in_valid;
  logic                 in_first;
  logic                 in_ready;
  logic signed [DW-1:0] inReal0;
  logic signed [DW-1:0] inImag0;
  logic signed [DW-1:0] inReal1;
  logic signed [DW-1:0] inImag1;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] outReal;
  logic signed [DW-1:0] outImag;
  logic [LOGN-1:0]      out_idx;
  logic                 out_first;
  logic                 out_last;
  logic                 err_drop;

  // Environment side: produces pairs, consumes bins.
  modport master (
    output in_valid, in_first, inReal0, inImag0, inReal1, inImag1, out_ready,
    input  in_ready, out_valid, outReal, outImag, out_idx, out_first, out_last, err_drop
  );

  // Reorder block side.
  modport slave (
    input  in_valid, in_first, inReal0, inImag0, inReal1, inImag1, out_ready,
    output in_ready, out_valid, outReal, outImag, out_idx, out_first, out_last, err_drop
  );

endinterface

// File: rtl/fft_pp_bank.sv
// One ping-pong buffer: a lane-0 bank (bins 0..N/2-1) and a lane-1 bank
// (bins N/2..N-1), written two lanes at a time and read one bin at a time.
module fft_pp_bank
  import fft_pkg::*;
(
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  sample_t [1:0]   wdata,
  input  logic            re,
  input  logic [LOGN-1:0] raddr,
  output sample_t         rdata
);

  logic lane_sel;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    sample_t mem [HALF];
    sample_t q;

    // Both lanes share the write address; each lane owns its half of the bins.
    always_ff @(posedge clk) begin
      if (we) begin
        mem[waddr] <= wdata[gi];
      end
    end

    // Registered read; the register holds its value while re is low.
    always_ff @(posedge clk) begin
      if (re) begin
        q <= mem[raddr[AW-1:0]];
      end
    end
  end

  // Remember which lane bank the held read belongs to.
  always_ff @(posedge clk) begin
    if (re) begin
      lane_sel <= raddr[LOGN-1];
    end
  end

  assign rdata = lane_sel ? g_lane[1].q : g_lane[0].q;

endmodule

// File: rtl/fft_out_reorder.sv
// Captures bit-reversed FFT pairs into a ping-pong buffer and drains each frame
// in natural bin order, one bin per cycle, behind a valid/ready output stage.
module fft_out_reorder
  import fft_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  fft_out_reorder_if.slave bus
);

  logic [AW-1:0]   wr_cnt, wr_cnt_next;
  logic            wr_buf, wr_buf_next;
  logic [LOGN-1:0] rd_cnt, rd_cnt_next;
  logic            rd_buf, rd_buf_next;
  logic [1:0]      full, full_next;
  logic            out_valid, out_valid_next;
  logic [LOGN-1:0] out_idx, out_idx_next;
  logic            out_buf, out_buf_next;
  logic            err_drop, err_drop_next;

  logic            accept, store, drop, complete, load, rel_buf;
  logic [AW-1:0]   pair_idx, wr_addr;
  logic [1:0]      we_vec, re_vec;
  sample_t [1:0]   wr_data;
  sample_t         rd_data [2];
  sample_t         out_sample;

  // Write side: an in_first pair always restarts the frame at pair 0;
  // a non-first pair with no frame open is discarded.
  assign accept   = bus.in_valid && !full[wr_buf];
  assign pair_idx = bus.in_first ? '0 : wr_cnt;
  assign store    = accept && (bus.in_first || wr_cnt != '0);
  assign drop     = accept && !bus.in_first && wr_cnt == '0;
  assign complete = store && pair_idx == AW'(HALF - 1);
  assign wr_addr  = AW'(bitrev(int'(pair_idx), AW));
  assign wr_data[0] = {bus.inReal0, bus.inImag0};
  assign wr_data[1] = {bus.inReal1, bus.inImag1};

  // Read side: load the next bin whenever the output register is free or handing off.
  assign load    = full[rd_buf] && (!out_valid || bus.out_ready);
  assign rel_buf = load && rd_cnt == LOGN'(N - 1);

  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    assign we_vec[gi] = store && (wr_buf == 1'(gi));
    assign re_vec[gi] = load && (rd_buf == 1'(gi));

    fft_pp_bank u_bank (
      .clk   (clk),
      .we    (we_vec[gi]),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (re_vec[gi]),
      .raddr (rd_cnt),
      .rdata (rd_data[gi])
    );
  end

  // Next-state for write counter, buffer ownership and output stage.
  always_comb begin
    wr_cnt_next    = wr_cnt;
    wr_buf_next    = wr_buf;
    rd_cnt_next    = rd_cnt;
    rd_buf_next    = rd_buf;
    full_next      = full;
    out_valid_next = out_valid;
    out_idx_next   = out_idx;
    out_buf_next   = out_buf;
    err_drop_next  = drop;

    if (store) begin
      if (complete) begin
        wr_cnt_next = '0;
        wr_buf_next = ~wr_buf;
      end else begin
        wr_cnt_next = pair_idx + 1'b1;
      end
    end

    // Completion and release touch different buffers, so both always apply.
    if (complete) begin
      full_next[wr_buf] = 1'b1;
    end
    if (rel_buf) begin
      full_next[rd_buf] = 1'b0;
    end

    if (load) begin
      out_valid_next = 1'b1;
      out_idx_next   = rd_cnt;
      out_buf_next   = rd_buf;
      rd_cnt_next    = rd_cnt + 1'b1;
      if (rel_buf) begin
        rd_buf_next = ~rd_buf;
      end
    end else if (bus.out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  // State registers; reset drops any partial or buffered frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_cnt    <= '0;
      wr_buf    <= 1'b0;
      rd_cnt    <= '0;
      rd_buf    <= 1'b0;
      full      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_buf   <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      wr_cnt    <= wr_cnt_next;
      wr_buf    <= wr_buf_next;
      rd_cnt    <= rd_cnt_next;
      rd_buf    <= rd_buf_next;
      full      <= full_next;
      out_valid <= out_valid_next;
      out_idx   <= out_idx_next;
      out_buf   <= out_buf_next;
      err_drop  <= err_drop_next;
    end
  end

  // Bank read registers carry no reset, so data is forced to zero when not valid.
  assign out_sample    = out_buf ? rd_data[1] : rd_data[0];
  assign bus.outReal   = out_valid ? out_sample.re : '0;
  assign bus.outImag   = out_valid ? out_sample.im : '0;
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = out_idx;
  assign bus.out_first = out_valid && out_idx == '0;
  assign bus.out_last  = out_valid && out_idx == LOGN'(N - 1);
  assign bus.in_ready  = !full[wr_buf];
  assign bus.err_drop  = err_drop;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: single frame, backpressure, back-to-back
// frames, resync, stray pairs and reset during drain.
module tb_fft_out_reorder;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  fft_out_reorder_if bus ();

  fft_out_reorder dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 0;
  bit acc_flag;
  int last_acc_cyc;
  int first_valid_cyc;
  int frame_first_acc;
  int n_drop;
  int n_stall;
  int q_idx[$];
  int q_re[$];
  int q_im[$];
  int q_fl[$];
  int q_cyc[$];
  bit prev_hold;
  logic [2*DW+LOGN+2:0] prev_word;
  logic [2*DW+LOGN+2:0] cur_word;

  task automatic chk(input string tag, input int obs, input int want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < LOGN - 1; i++) begin
      if (v[i]) r = r | (1 << (LOGN - 2 - i));
    end
    return r;
  endfunction

  function automatic int exp_re(input int base, input int b);
    return (b < HALF) ? base + brev(b) : base + brev(b - HALF) + 100;
  endfunction

  function automatic int exp_im(input int base, input int b);
    return (b < HALF) ? -(base + brev(b)) : base;
  endfunction

  // One clock: set out_ready, observe this cycle, then advance past the edge.
  task automatic step();
    case (rdy_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: bus.out_ready = 1'b0;
    endcase
    cur_word = {bus.out_valid, bus.out_idx, bus.outReal, bus.outImag, bus.out_first, bus.out_last};
    if (prev_hold) begin
      total++;
      assert (cur_word === prev_word) else begin
        bad++;
        $error("FAIL hold_stable observed=%h expected=%h", cur_word, prev_word);
      end
    end
    prev_hold = bus.out_valid && !bus.out_ready;
    prev_word = cur_word;
    if (bus.out_valid && bus.out_ready) begin
      q_idx.push_back(int'(bus.out_idx));
      q_re.push_back(int'(bus.outReal));
      q_im.push_back(int'(bus.outImag));
      q_fl.push_back(int'({bus.out_first, bus.out_last}));
      q_cyc.push_back(cyc);
    end
    if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.in_valid && bus.in_ready) begin
      acc_flag = 1'b1;
      last_acc_cyc = cyc;
    end
    if (bus.in_valid && !bus.in_ready) n_stall++;
    if (bus.err_drop) n_drop++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_pair(input int re0, input int im0, input int re1, input int im1, input bit first);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_first = first;
    bus.inReal0  = DW'(re0);
    bus.inImag0  = DW'(im0);
    bus.inReal1  = DW'(re1);
    bus.inImag1  = DW'(im1);
    acc_flag = 1'b0;
    while (!acc_flag && guard < 200) begin
      step();
      guard++;
    end
    if (!acc_flag) chk("accept_timeout", int'(acc_flag), 1);
  endtask

  task automatic send_frame(input int base);
    for (int k = 0; k < HALF; k++) begin
      send_pair(base + k, -(base + k), base + k + 100, base, k == 0);
      if (k == 0) frame_first_acc = last_acc_cyc;
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain(input int n);
    int guard = 0;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    while (q_idx.size() < n && guard < 1000) begin
      step();
      guard++;
    end
  endtask

  task automatic check_frame(input string tag, input int base, input int off);
    $display("txn %s base=%0d bins_seen=%0d", tag, base, q_idx.size());
    if (q_idx.size() < off + N) begin
      chk({tag, "_count"}, q_idx.size(), off + N);
      return;
    end
    for (int b = 0; b < N; b++) begin
      chk($sformatf("%s_idx%0d", tag, b), q_idx[off+b], b);
      chk($sformatf("%s_re%0d", tag, b), q_re[off+b], exp_re(base, b));
      chk($sformatf("%s_im%0d", tag, b), q_im[off+b], exp_im(base, b));
      chk($sformatf("%s_firstlast%0d", tag, b), q_fl[off+b],
          ((b == 0) ? 2 : 0) + ((b == N - 1) ? 1 : 0));
    end
  endtask

  task automatic clear_obs();
    q_idx.delete();
    q_re.delete();
    q_im.delete();
    q_fl.delete();
    q_cyc.delete();
    first_valid_cyc = -1;
    n_drop = 0;
    n_stall = 0;
    prev_hold = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    nrst = 1'b0;
    step();
    step();
    nrst = 1'b1;
    step();
    clear_obs();
  endtask

  initial begin
    int b_end;
    int c_first;
    int gaps;

    nrst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.inReal0 = '0;
    bus.inImag0 = '0;
    bus.inReal1 = '0;
    bus.inImag1 = '0;
    bus.out_ready = 1'b1;
    clear_obs();

    // Reset state
    step();
    step();
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_outReal", int'(bus.outReal), 0);
    chk("rst_outImag", int'(bus.outImag), 0);
    chk("rst_out_idx", int'(bus.out_idx), 0);
    chk("rst_out_first", int'(bus.out_first), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_err_drop", int'(bus.err_drop), 0);
    nrst = 1'b1;
    step();
    chk("post_rst_out_valid", int'(bus.out_valid), 0);

    // Single frame
    rdy_mode = 0;
    do_reset();
    send_frame(0);
    drain(N);
    chk("t1_latency", first_valid_cyc - last_acc_cyc, 2);
    check_frame("t1", 0, 0);
    if (q_idx.size() >= N) begin
      chk("t1_bin1_re", q_re[1], 16);
      chk("t1_bin1_im", q_im[1], -16);
      chk("t1_bin2_re", q_re[2], 8);
      chk("t1_bin2_im", q_im[2], -8);
      chk("t1_bin33_re", q_re[33], 116);
      chk("t1_bin33_im", q_im[33], 0);
      chk("t1_bin63_re", q_re[63], 131);
      chk("t1_bin63_im", q_im[63], 0);
    end

    // Backpressure
    do_reset();
    rdy_mode = 1;
    send_frame(5);
    drain(N);
    idle(10);
    chk("t2_count", q_idx.size(), N);
    check_frame("t2", 5, 0);
    rdy_mode = 0;

    // Back-to-back frames
    do_reset();
    send_frame(10);
    send_frame(20);
    b_end = last_acc_cyc;
    chk("t3_ab_no_stall", n_stall, 0);
    n_stall = 0;
    send_frame(30);
    c_first = frame_first_acc;
    drain(3 * N);
    if (q_idx.size() >= N) begin
      chk("t3_c_accept_cycle", c_first, q_cyc[N-1]);
      chk("t3_stall_len", n_stall, q_cyc[N-1] - b_end - 1);
    end
    check_frame("t3a", 10, 0);
    check_frame("t3b", 20, N);
    check_frame("t3c", 30, 2 * N);
    gaps = 0;
    for (int i = 1; i < q_cyc.size(); i++) begin
      if (q_cyc[i] != q_cyc[i-1] + 1) gaps++;
    end
    chk("t3_bubbles", gaps, 0);

    // Resync at wr_cnt = 10
    do_reset();
    for (int k = 0; k < 10; k++) begin
      send_pair(40 + k, -(40 + k), 140 + k, 40, k == 0);
    end
    send_frame(50);
    drain(N);
    idle(80);
    chk("t4_count", q_idx.size(), N);
    chk("t4_no_drop", n_drop, 0);
    check_frame("t4", 50, 0);

    // Stray pairs without a frame start
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send_pair(7, 7, 7, 7, 1'b0);
    end
    idle(20);
    chk("t5_drops", n_drop, 3);
    chk("t5_no_output", q_idx.size(), 0);
    send_frame(60);
    drain(N);
    check_frame("t5", 60, 0);

    // Reset mid-drain with a second frame buffered
    do_reset();
    rdy_mode = 2;
    send_frame(70);
    send_frame(80);
    rdy_mode = 0;
    drain(20);
    chk("t6_at_bin20_valid", int'(bus.out_valid), 1);
    chk("t6_at_bin20_idx", int'(bus.out_idx), 20);
    nrst = 1'b0;
    #1;
    chk("t6_rst_out_valid", int'(bus.out_valid), 0);
    chk("t6_rst_in_ready", int'(bus.in_ready), 1);
    prev_hold = 1'b0;
    step();
    nrst = 1'b1;
    clear_obs();
    idle(150);
    chk("t6_nothing_after_rst", q_idx.size(), 0);
    send_frame(90);
    drain(N);
    check_frame("t6", 90, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Consumer at the output end of the in-place radix-2 DIF FFT. The FFT delivers each frame as N/2 two-lane sample pairs in bit-reversed bin order.
- Deswizzles each frame into natural bin order and emits it as a serial one-bin-per-cycle stream with valid/ready handshake and frame markers.
- Double-buffered (ping-pong): one frame is captured while the previous one drains.

Parameters:
- DW, 16, width of real and imaginary parts (two's complement).
- LOGN, 6, log2 of FFT length; N = 2**LOGN bins; N/2 pairs per frame.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- in_valid  in  1  current pair is valid.
- in_first  in  1  current pair is pair 0 of a frame.
- in_ready  out  1  a free capture buffer exists.
- inReal0, inImag0  in  DW each  lane-0 sample of the pair.
- inReal1, inImag1  in  DW each  lane-1 sample of the pair.
- out_valid  out  1  output bin is valid.
- out_ready  in  1  downstream accepts the bin.
- outReal, outImag  out  DW each  bin value.
- out_idx  out  LOGN  bin number of the current output.
- out_first, out_last  out  1 each  high on bin 0 / bin N-1.
- err_drop  out  1  one-cycle pulse when a pair is discarded.

Behaviour:
- Pair mapping: pair k (0..N/2-1) carries lane0 = bin bitrev_LOGN(2k) = bitrev_(LOGN-1)(k) and lane1 = that bin + N/2.
- Storage: 2 buffers x 2 banks (lane0 bank = bins 0..N/2-1, lane1 bank = bins N/2..N-1) x N/2 entries of 2*DW bits. Write address = bitrev_(LOGN-1)(wr_cnt).
- Accept condition: in_valid && in_ready. in_ready = !full[wr_buf]. Gaps in in_valid are allowed mid-frame.
- Write counter, pair accepted at wr_cnt==0:
  - with in_first: stored.
  - without in_first: discarded, err_drop pulses, wr_cnt stays 0.
- Resync: in_first accepted while wr_cnt!=0 restarts the frame. That pair is stored as pair 0, wr_cnt becomes 1, no err_drop.
- Frame completion: accepting pair N/2-1 sets full[wr_buf], toggles wr_buf and clears wr_cnt. The next pair is accepted only if the other buffer is free.
- Read side, registered output stage:
  - When the output register is empty or being handed off and full[rd_buf] is set, the stage loads bin rd_cnt (bank = rd_cnt[LOGN-1], addr = rd_cnt[LOGN-2:0]) and sets out_valid.
  - rd_cnt increments per load.
- Handshake: out_valid and all out_* fields stay stable while out_valid && !out_ready.
- Latency: last pair presented and accepted in cycle c gives bin 0 with out_valid in cycle c+2, when the read side is idle.
- Buffer release: when bin N-1 is loaded into the output register, full[rd_buf] clears, rd_buf toggles and rd_cnt wraps to 0.
  - If the other buffer is already full, its bin 0 follows out_last with no bubble under continuous out_ready.
  - Release and write completion in the same cycle are both honoured. in_ready rises the cycle after release.
- Throughput: capture is 2 bins/cycle and drain is 1 bin/cycle, so sustained frames stall the input through in_ready. Data is never lost once accepted.
- Reset, asynchronous, any time including mid-frame:
  - wr_cnt = rd_cnt = 0; wr_buf = rd_buf = 0; full = 0.
  - in_ready = 1; out_valid = 0; outReal = outImag = 0; out_idx = 0.
  - out_first = out_last = 0; err_drop = 0.
  - Partial frames are lost. Buffer contents are don't-care.

Decomposition:
- Shared package fft_pkg: DW, LOGN, N constants; bitrev function parameterised by width; a sample-pair typedef {re, im}.
- One sub-module fft_pp_bank: one ping-pong buffer holding both lane banks, with 1 write port (2 lanes) and 1 read port.
- fft_out_reorder instantiates fft_pp_bank twice.

Test Plan:
- Single frame: pair k has inReal0=k, inReal1=k+100, inImag0=-k, inImag1=0, in_valid continuous, out_ready=1. Required:
  - bins appear 0..63 in order;
  - bin 1 = (16, -16); bin 2 = (8, -8); bin 33 = (116, 0); bin 63 = (131, 0);
  - bin 0 valid exactly 2 cycles after pair 31 is accepted.
- Backpressure: same frame, out_ready toggling 1,0,0,1 repeatedly. Required: 64 bins, each held stable while stalled, no duplicates or skips, out_first on bin 0 only, out_last on bin 63 only.
- Back-to-back frames A, B, C with continuous in_valid. Required:
  - A and B captured without stall;
  - in_ready low from end of B until A's bin 63 is loaded;
  - C accepted one cycle later;
  - output A then B then C with no bubble between frames.
- Resync: in_first reasserted at wr_cnt=10, then a full frame. Required: exactly one 64-bin frame output equal to the new frame; err_drop never pulses.
- Stray data: 3 pairs with in_valid=1, in_first=0 after reset. Required: err_drop pulses 3 times, no output; a following proper frame is output correctly.
- Reset mid-drain: nrst low for 1 cycle at bin 20 of frame A with frame B buffered. Required: out_valid=0, in_ready=1 immediately; nothing from A or B is output afterwards; a new frame then outputs correctly.
